// File: rtl/r200memarb_pkg.sv
// r200memarb_pkg: shared encodings for the unified-memory arbiter.
//   state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   owner_t : which port owns the transaction currently in flight
package r200memarb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

endpackage

// File: rtl/r200memarb_latcnt.sv
// r200latcnt: loadable down-counter used to time fixed-latency units.
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   ld, val    : load val into the counter (has priority over decrement)
//   zero_next  : high when the count is 1, i.e. it reaches 0 at the next edge
// The counter decrements every cycle while non-zero and parks at 0.
module r200latcnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [W-1:0] val,
   output logic         zero_next
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (ld)
         cnt <= val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign zero_next = (cnt == W'(1));

endmodule

// File: rtl/r200memarb.sv
// r200memarb: arbitrates a single-port unified memory between instruction
// fetch (I port, read-only) and the MEM stage (D port, read/write).
//   clk, rst                         : clock, synchronous active-high reset
//   i_req/i_addr/i_flush             : fetch request, address, redirect flush
//   i_ack/i_rdata                    : 1-cycle fetch completion + instruction
//   d_req/d_we/d_addr/d_wdata        : data request (store when d_we=1)
//   d_ack/d_rdata                    : 1-cycle completion, load data (0 on store)
//   m_en/m_we/m_addr/m_wdata/m_rdata : memory macro interface
// D wins arbitration unless I has watched STARVE_MAX consecutive D grants.
// Every access takes MEM_LAT+2 cycles: grant edge, MEM_LAT ACCESS cycles, RESP.
module r200memarb
   import r200memarb_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   input  logic            i_flush,
   output logic            i_ack,
   output logic [XLEN-1:0] i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic            d_ack,
   output logic [XLEN-1:0] d_rdata,
   output logic            m_en,
   output logic            m_we,
   output logic [XLEN-1:0] m_addr,
   output logic [XLEN-1:0] m_wdata,
   input  logic [XLEN-1:0] m_rdata
);

   localparam int CW = $clog2(MEM_LAT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   state_t          state;
   owner_t          owner;
   logic            we_q;    // latched we; m_we itself is only a 1-cycle strobe
   logic            drop;    // fetch flushed while in flight: swallow its ack
   logic [SW-1:0]   starv;
   logic            zero_next;
   logic            i_ok;
   logic            i_win;
   logic            grant;
   logic [XLEN-1:0] rd;

   // A flushing fetch may not win in the same cycle.
   assign i_ok  = i_req && !i_flush;
   assign i_win = i_ok && (!d_req || (starv == SW'(STARVE_MAX)));
   assign grant = (state == ST_IDLE) && (d_req || i_ok);
   assign rd    = we_q ? '0 : m_rdata;

   r200latcnt #(.W(CW)) u_latcnt (
      .clk       (clk),
      .rst       (rst),
      .ld        (grant),
      .val       (CW'(MEM_LAT)),
      .zero_next (zero_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         owner   <= OWN_NONE;
         we_q    <= 1'b0;
         drop    <= 1'b0;
         starv   <= '0;
         i_ack   <= 1'b0;
         i_rdata <= '0;
         d_ack   <= 1'b0;
         d_rdata <= '0;
         m_en    <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         m_en  <= 1'b0;
         m_we  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!i_req)
                  starv <= '0;
               if (grant) begin
                  state <= ST_ACCESS;
                  drop  <= 1'b0;
                  m_en  <= 1'b1;
                  if (i_win) begin
                     owner   <= OWN_I;
                     we_q    <= 1'b0;
                     m_addr  <= i_addr;
                     m_wdata <= '0;
                     starv   <= '0;
                  end else begin
                     owner   <= OWN_D;
                     we_q    <= d_we;
                     m_we    <= d_we;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                     if (i_req && (starv != SW'(STARVE_MAX)))
                        starv <= starv + SW'(1);
                  end
               end
            end
            ST_ACCESS: begin
               if (owner == OWN_I && i_flush)
                  drop <= 1'b1;
               if (zero_next) begin
                  state <= ST_RESP;
                  if (owner == OWN_I) begin
                     // Include a flush arriving in this very cycle.
                     if (!(drop || i_flush)) begin
                        i_ack   <= 1'b1;
                        i_rdata <= rd;
                     end
                  end else begin
                     d_ack   <= 1'b1;
                     d_rdata <= rd;
                  end
               end
            end
            ST_RESP: begin
               if (owner == OWN_I && i_flush)
                  drop <= 1'b1;
               state <= ST_IDLE;
               owner <= OWN_NONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_r200memarb.sv
// tb_r200memarb: two arbiters (MEM_LAT=2/STARVE_MAX=2 and MEM_LAT=1/
// STARVE_MAX=4) share one stimulus stream. A transaction-level model
// predicts each one's outputs every cycle; directed literal checks pin the
// headline timing on top of that.
module tb_r200memarb;

   logic        clk = 1'b0;
   logic        rst, i_req, i_flush, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;

   logic        a_i_ack, a_d_ack, a_m_en, a_m_we;
   logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
   logic        b_i_ack, b_d_ack, b_m_en, b_m_we;
   logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      case (a)
         32'h100: return 32'hDEADBEEF;
         32'h40:  return 32'hCAFEF00D;
         default: return {a[15:0], 16'hA5A5};
      endcase
   endfunction

   assign a_m_rdata = memf(a_m_addr);
   assign b_m_rdata = memf(b_m_addr);

   r200memarb #(.XLEN(32), .MEM_LAT(2), .STARVE_MAX(2)) ua (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_ack(a_i_ack), .i_rdata(a_i_rdata), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(a_d_ack), .d_rdata(a_d_rdata),
      .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
      .m_rdata(a_m_rdata));

   r200memarb #(.XLEN(32), .MEM_LAT(1), .STARVE_MAX(4)) ub (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_ack(b_i_ack), .i_rdata(b_i_rdata), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
      .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
      .m_rdata(b_m_rdata));

   // ---------------- transaction-level model ----------------
   // A grant made at the end of cycle g occupies the memory until the end of
   // cycle g+lat+1: strobe in g+1, data captured at the end of g+lat, ack
   // visible in g+lat+1.
   typedef struct packed {
      logic        busy, own_i, we, drop;
      int          g, starv;
      logic [31:0] addr, wdata, i_rdata, d_rdata;
      logic        i_ack, d_ack, m_en, m_we;
   } mst_t;

   mst_t ma, mb;

   task automatic step(inout mst_t s, input int lat, input int smax, input int c);
      int          k;
      logic [31:0] dat;
      logic        iok;
      if (rst) begin
         s = '0;
      end else begin
         s.i_ack = 1'b0; s.d_ack = 1'b0; s.m_en = 1'b0; s.m_we = 1'b0;
         if (s.busy) begin
            k = c - s.g;
            if (s.own_i && i_flush && k <= lat) s.drop = 1'b1;
            if (k == lat) begin
               dat = s.we ? 32'h0 : memf(s.addr);
               if (s.own_i) begin
                  if (!s.drop) begin s.i_ack = 1'b1; s.i_rdata = dat; end
               end else begin
                  s.d_ack = 1'b1; s.d_rdata = dat;
               end
            end
            if (k == lat + 1) s.busy = 1'b0;
         end else begin
            iok = i_req && !i_flush;
            if (!i_req) s.starv = 0;
            if (d_req || iok) begin
               s.own_i = iok && (!d_req || s.starv == smax);
               if (s.own_i) begin
                  s.starv = 0; s.addr = i_addr; s.we = 1'b0; s.wdata = 32'h0;
               end else begin
                  if (i_req && s.starv < smax) s.starv = s.starv + 1;
                  s.addr = d_addr; s.we = d_we; s.wdata = d_wdata;
               end
               s.busy = 1'b1; s.g = c; s.drop = 1'b0;
               s.m_en = 1'b1; s.m_we = s.we;
            end
         end
      end
   endtask

   always @(posedge clk) begin
      step(ma, 2, 2, cyc);
      step(mb, 1, 4, cyc);
      cyc = cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_dut(input string p, input mst_t s,
                          input logic ia, input logic [31:0] ird,
                          input logic da, input logic [31:0] drd,
                          input logic me, input logic mw,
                          input logic [31:0] ma_, input logic [31:0] mwd);
      chk({p, ".i_ack"},   {31'b0, ia}, {31'b0, s.i_ack});
      chk({p, ".i_rdata"}, ird,         s.i_rdata);
      chk({p, ".d_ack"},   {31'b0, da}, {31'b0, s.d_ack});
      chk({p, ".d_rdata"}, drd,         s.d_rdata);
      chk({p, ".m_en"},    {31'b0, me}, {31'b0, s.m_en});
      chk({p, ".m_we"},    {31'b0, mw}, {31'b0, s.m_we});
      chk({p, ".m_addr"},  ma_,         s.addr);
      chk({p, ".m_wdata"}, mwd,         s.wdata);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_dut("a", ma, a_i_ack, a_i_rdata, a_d_ack, a_d_rdata, a_m_en, a_m_we, a_m_addr, a_m_wdata);
         cmp_dut("b", mb, b_i_ack, b_i_rdata, b_d_ack, b_d_rdata, b_m_en, b_m_we, b_m_addr, b_m_wdata);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   logic [31:0] ga [4];
   int          gi;

   initial begin
      ma = '0; mb = '0;
      rst = 1'b1; i_req = 1'b0; i_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      @(posedge clk);
      chk_en = 1'b1;
      tick(); tick();
      chk("rst.m_en",    {31'b0, a_m_en}, 32'h0);
      chk("rst.d_rdata", a_d_rdata, 32'h0);
      chk("rst.i_rdata", b_i_rdata, 32'h0);
      rst = 1'b0;

      // T1: single fetch, MEM_LAT=2
      i_req = 1'b1; i_addr = 32'h100;
      tick(); chk("t1.m_en", {31'b0, a_m_en}, 32'h1); chk("t1.m_addr", a_m_addr, 32'h100);
      tick(); chk("t1.no_ack_c2", {31'b0, a_i_ack}, 32'h0);
      tick(); chk("t1.i_ack_c3", {31'b0, a_i_ack}, 32'h1); chk("t1.i_rdata", a_i_rdata, 32'hDEADBEEF);
      i_req = 1'b0;
      tick();

      // T2: simultaneous fetch and store; D goes first
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
      tick(); chk("t2.m_we", {31'b0, a_m_we}, 32'h1); chk("t2.m_addr_d", a_m_addr, 32'h200);
      tick();
      tick(); chk("t2.d_ack_c3", {31'b0, a_d_ack}, 32'h1); chk("t2.d_rdata", a_d_rdata, 32'h0);
      d_req = 1'b0; d_we = 1'b0;
      tick();
      tick(); chk("t2.i_issue_c5", {31'b0, a_m_en}, 32'h1); chk("t2.m_addr_i", a_m_addr, 32'h100);
      tick();
      tick(); chk("t2.i_ack_c7", {31'b0, a_i_ack}, 32'h1);
      i_req = 1'b0;
      tick();

      // T3: starvation guard with STARVE_MAX=2 -> D, D, I, D
      i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      gi = 0;
      for (int t = 1; t <= 15; t++) begin
         tick();
         if (a_m_en && gi < 4) begin ga[gi] = a_m_addr; gi++; end
         if (t == 15) begin i_req = 1'b0; d_req = 1'b0; end
      end
      chk("t3.ngrants", gi, 4);
      chk("t3.g0", ga[0], 32'h400);
      chk("t3.g1", ga[1], 32'h400);
      chk("t3.g2", ga[2], 32'h300);
      chk("t3.g3", ga[3], 32'h400);
      tick(); tick();

      // T4: flush during a fetch; queued load granted when IDLE is reached
      i_req = 1'b1; i_addr = 32'h500;
      tick(); tick();
      i_flush = 1'b1; i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
      tick(); i_flush = 1'b0; chk("t4.no_ack_c3", {31'b0, a_i_ack}, 32'h0);
      tick(); chk("t4.no_ack_c4", {31'b0, a_i_ack}, 32'h0);
      tick(); chk("t4.d_issue_c5", {31'b0, a_m_en}, 32'h1); chk("t4.m_addr", a_m_addr, 32'h600);
      tick();
      tick(); chk("t4.d_ack_c7", {31'b0, a_d_ack}, 32'h1); chk("t4.d_rdata", a_d_rdata, 32'h0600A5A5);
      d_req = 1'b0;
      tick();

      // T5: reset in the first ACCESS cycle of a load
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
      tick(); chk("t5.m_en_c1", {31'b0, a_m_en}, 32'h1);
      rst = 1'b1;
      tick();
      chk("t5.m_en",   {31'b0, a_m_en}, 32'h0);
      chk("t5.m_addr", a_m_addr, 32'h0);
      chk("t5.i_rdata", a_i_rdata, 32'h0);
      rst = 1'b0; d_req = 1'b0;
      for (int t = 0; t < 4; t++) begin
         tick(); chk("t5.no_d_ack", {31'b0, a_d_ack}, 32'h0);
      end

      // T6: MEM_LAT=1 load then store on instance b
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      tick();
      tick(); chk("t6.b_d_ack_c2", {31'b0, b_d_ack}, 32'h1); chk("t6.b_load", b_d_rdata, 32'hCAFEF00D);
      d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h55;
      tick(); tick();
      tick(); chk("t6.b_st_ack_c5", {31'b0, b_d_ack}, 32'h1); chk("t6.b_store", b_d_rdata, 32'h0);
      d_req = 1'b0; d_we = 1'b0;
      for (int t = 0; t < 8; t++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
